shift_add_multiplier: RTL

Sequential 4x4 unsigned multiplier built on the team's 4-bit `ripple_carry_adder`. The adder is used once per cycle as the accumulate datapath. The block latches two operands on a start pulse and runs one shift-and-add iteration per clock. It presents an 8-bit product with a single-cycle done strobe. It is the first sequential consumer of the adder's `Sum`/`Cout` outputs and the template for later iterative arithmetic blocks.

---
 rtl/shift_add_pkg.sv | 14 +
 rtl/ripple_carry_adder.sv | 24 ++
 rtl/shift_add_multiplier.sv | 113 +++++++++++
 3 files changed

// File: rtl/shift_add_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// The SHIFT_ADD_EARLY_DONE_EN build option is resolved in the top module.
package shift_add_pkg;

  localparam int SA_WIDTH = 4;
  localparam int SA_ITER  = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sa_state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder.
// Purely combinational; the carry chain runs LSB to MSB.
module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[4];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// Define SHIFT_ADD_EARLY_DONE_EN to finish once the multiplier bits run out.
module shift_add_multiplier
  import shift_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               busy,
  output logic               done
);

  if (WIDTH != SA_WIDTH) begin : g_bad_width
    $error("shift_add_multiplier: WIDTH must equal SA_WIDTH");
  end

  sa_state_t state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [8:0] p_q, p_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;

  logic [3:0] sum;
  logic       cout;
  logic [8:0] p_step;

  ripple_carry_adder u_adder (
    .A    (p_q[7:4]),
    .B    (mcand_q),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

`ifdef SHIFT_ADD_EARLY_DONE_EN
  logic [4:0] rem_mask;
  logic       rem_zero;

  // Only the cnt low bits of P[3:0] are still unconsumed multiplier bits.
  always_comb begin
    rem_mask = (5'd1 << cnt_q) - 5'd1;
    rem_zero = (p_q[3:0] & rem_mask[3:0]) == 4'd0;
  end
`endif

  always_comb begin
    p_step = p_q[0] ? {1'b0, cout, sum, p_q[3:1]}
                    : {1'b0, p_q[8:4], p_q[3:1]};
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = A;
          p_d     = {5'b0, B};
          cnt_d   = 3'(SA_ITER);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d   = p_step;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          product_d = p_step[7:0];
          state_d   = DONE;
        end
`ifdef SHIFT_ADD_EARLY_DONE_EN
        if (rem_zero) begin
          p_d       = p_q;
          cnt_d     = cnt_q;
          product_d = p_q[7:0] >> cnt_q;
          state_d   = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign Product = product_q;
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);

endmodule
